// File: rtl/mem_fifo_ctrl.sv
// FIFO controller wrapped around a dual-port mem: circular write addressing upstream,
// one-entry registered output stage downstream. Optional almost flags: MEM_FIFO_ALMOST_FLAGS_EN.
module mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 8
`ifdef MEM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL   = (2 ** ADD_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  mem_wr_en,
  output logic [ADD_WIDTH-1:0]  mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADD_WIDTH-1:0]  mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
`ifdef MEM_FIFO_ALMOST_FLAGS_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic [ADD_WIDTH:0]    level
);

  // Handshake: a word moves on a side only in a cycle where valid and ready are
  // both high at the rising edge; valid never depends on ready of the same side.

  logic [ADD_WIDTH:0]    wr_ptr_q, wr_ptr_d;
  logic [ADD_WIDTH:0]    rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  rdy_q;
  logic                  empty, full, wr_fire, load;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADD_WIDTH-1:0] == rd_ptr_q[ADD_WIDTH-1:0]) &&
                   (wr_ptr_q[ADD_WIDTH] != rd_ptr_q[ADD_WIDTH]);
  assign in_ready = rdy_q && !full && !flush;
  assign wr_fire  = in_valid && in_ready;
  assign load     = !empty && (!out_valid_q || out_ready) && !flush;

  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wr_ptr_q[ADD_WIDTH-1:0];
  assign mem_wr_data = in_data;
  assign mem_rd_en   = load;
  assign mem_rd_addr = rd_ptr_q[ADD_WIDTH-1:0];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = mem_rd_data;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // rdy_q keeps in_ready low throughout reset and for the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rdy_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rdy_q       <= 1'b1;
    end
  end

`ifdef MEM_FIFO_ALMOST_FLAGS_EN
  logic               almost_full_q, almost_empty_q;
  logic [ADD_WIDTH:0] level_d;

  assign level_d      = wr_ptr_d - rd_ptr_d;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (int'(level_d) >= AF_LEVEL);
      almost_empty_q <= (int'(level_d) <= AE_LEVEL);
    end
  end
`endif

endmodule
